// File: rtl/cmd_apb_bridge.sv
// Command-to-APB4 bridge: one APB transfer per GET/SET, QUERY returns the transfer count.
// Define CMD_APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without pready_i.
module cmd_apb_bridge #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_vld_i,
    output logic                  cmd_rdy_o,
    input  logic [1:0]            cmd_cmd_i,
    input  logic [3:0]            cmd_tag_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_val_i,
    output logic                  rsp_vld_o,
    input  logic                  rsp_rdy_i,
    output logic [3:0]            rsp_tag_o,
    output logic [DATA_WIDTH-1:0] rsp_val_o,
    output logic [1:0]            rsp_err_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [DATA_WIDTH-1:0] prdata_i
);
    // state  | meaning
    // IDLE   | cmd_rdy_o high, waiting for a command
    // SETUP  | APB setup phase (psel, no penable)
    // ACCESS | APB access phase, waiting for pready_i
    // RESP   | response valid, waiting for rsp_rdy_i
    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_SETUP  = 4'b0010,
        S_ACCESS = 4'b0100,
        S_RESP   = 4'b1000
    } state_t;

    localparam logic [1:0] CMD_GET   = 2'b00;
    localparam logic [1:0] CMD_SET   = 2'b01;
    localparam logic [1:0] CMD_QUERY = 2'b10;

    state_t                r_state;
    state_t                w_next;
    logic                  r_cmd_rdy;
    logic [1:0]            r_cmd;
    logic [3:0]            r_tag;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rsp_val;
    logic [1:0]            r_rsp_err;
    logic [15:0]           r_xfer_cnt;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_timeout;
    logic                  w_apb_phase;

    // cmd_rdy_o is registered so it stays low through reset and the release cycle
    assign w_accept    = r_cmd_rdy & cmd_vld_i;
    assign w_done      = (r_state == S_ACCESS) & pready_i;
    assign w_apb_phase = (r_state == S_SETUP) | (r_state == S_ACCESS);

`ifdef CMD_APB_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    // pready_i in the final cycle takes priority over the abort
    assign w_timeout = (r_state == S_ACCESS) & ~pready_i
                     & (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_to_cnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_ACCESS) && !pready_i) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end
`else
    logic w_unused_to;

    assign w_timeout   = 1'b0;
    assign w_unused_to = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next = cmd_cmd_i[1] ? S_RESP : S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_done || w_timeout) w_next = S_RESP;
            S_RESP:   if (rsp_rdy_i) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_cmd_rdy  <= 1'b0;
            r_cmd      <= '0;
            r_tag      <= '0;
            r_adr      <= '0;
            r_wdata    <= '0;
            r_rsp_val  <= '0;
            r_rsp_err  <= '0;
            r_xfer_cnt <= '0;
        end else begin
            r_cmd_rdy <= (w_next == S_IDLE);
            if (w_accept) begin
                r_cmd   <= cmd_cmd_i;
                r_tag   <= cmd_tag_i;
                r_adr   <= cmd_adr_i;
                r_wdata <= cmd_val_i;
                if (cmd_cmd_i == CMD_QUERY) begin
                    r_rsp_val <= DATA_WIDTH'(r_xfer_cnt);
                    r_rsp_err <= 2'b00;
                end else if (cmd_cmd_i[1]) begin
                    r_rsp_val <= '0;
                    r_rsp_err <= 2'b11;
                end
            end
            if (w_done) begin
                r_rsp_val  <= (r_cmd == CMD_GET) ? prdata_i : '0;
                r_rsp_err  <= {1'b0, pslverr_i};
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end else if (w_timeout) begin
                r_rsp_val <= '0;
                r_rsp_err <= 2'b10;
            end
        end
    end

    assign cmd_rdy_o = r_cmd_rdy;
    assign psel_o    = w_apb_phase;
    assign penable_o = (r_state == S_ACCESS);
    assign pwrite_o  = w_apb_phase & (r_cmd == CMD_SET);
    assign pstrb_o   = {STRB_WIDTH{pwrite_o}};
    assign paddr_o   = r_adr;
    assign pwdata_o  = r_wdata;
    assign rsp_vld_o = (r_state == S_RESP);
    assign rsp_tag_o = r_tag;
    assign rsp_val_o = r_rsp_val;
    assign rsp_err_o = r_rsp_err;
endmodule
